// File: rtl/led_pattern_gen.sv
// led_pattern_gen
// Prescaled LED pattern generator. Every DIV enabled clocks the LED register
// advances by one step of the pattern chosen by `mode`. A seed can be loaded at
// any time, and the synchronous reset clears the whole pipeline.
//
// Ports:
//   clk   - single clock, all state updates on its rising edge
//   rst   - synchronous, active-high reset (overrides everything)
//   en    - prescaler enable; prescaler and pattern hold while low
//   mode  - pattern select (0 hold, 1 fill, 2 shift, 3 invert, 4 rotate,
//           5 bounce, 6 count, 7 clear), sampled at each step edge
//   load  - load seed into led, restart prescaler, clear bounce direction
//   seed  - value loaded into led on load
//   led   - registered pattern output
//   step  - registered one-cycle pulse following each pattern step
module led_pattern_gen #(
    parameter int WIDTH = 8,
    parameter int DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] led,
    output logic             step
);

    // Prescaler needs at least one bit even when DIV==1.
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    localparam logic [2:0] MODE_HOLD   = 3'd0;
    localparam logic [2:0] MODE_FILL   = 3'd1;
    localparam logic [2:0] MODE_SHIFT  = 3'd2;
    localparam logic [2:0] MODE_INVERT = 3'd3;
    localparam logic [2:0] MODE_ROTATE = 3'd4;
    localparam logic [2:0] MODE_BOUNCE = 3'd5;
    localparam logic [2:0] MODE_COUNT  = 3'd6;
    localparam logic [2:0] MODE_CLEAR  = 3'd7;

    logic [CW-1:0]    cnt_q,  cnt_d;
    logic [WIDTH-1:0] led_q,  led_d;
    logic             dir_q,  dir_d;   // bounce direction: 0 = left, 1 = right
    logic             step_q, step_d;
    logic             step_edge_s;

    // Bounce helper: next LED value for the current direction.
    function automatic logic [WIDTH-1:0] bounce_led(input logic [WIDTH-1:0] cur,
                                                    input logic             dir);
        logic [WIDTH-1:0] res;
        if (cur == {WIDTH{1'b0}}) begin
            res = {{(WIDTH-1){1'b0}}, 1'b1};
        end else if (!dir && cur[WIDTH-1]) begin
            res = cur >> 1;
        end else if (dir && cur[0]) begin
            res = cur << 1;
        end else if (dir) begin
            res = cur >> 1;
        end else begin
            res = cur << 1;
        end
        return res;
    endfunction

    // Bounce helper: direction after the step; an empty pattern restarts leftwards.
    function automatic logic bounce_dir(input logic [WIDTH-1:0] cur,
                                        input logic             dir);
        logic res;
        if (cur == {WIDTH{1'b0}}) begin
            res = 1'b0;
        end else if (!dir && cur[WIDTH-1]) begin
            res = 1'b1;
        end else if (dir && cur[0]) begin
            res = 1'b0;
        end else begin
            res = dir;
        end
        return res;
    endfunction

    // Pattern step function for every mode.
    function automatic logic [WIDTH-1:0] next_led(input logic [WIDTH-1:0] cur,
                                                  input logic [2:0]       sel,
                                                  input logic             dir);
        logic [WIDTH-1:0] res;
        case (sel)
            MODE_HOLD:   res = cur;
            MODE_FILL:   res = (&cur) ? {WIDTH{1'b0}} : {1'b1, cur[WIDTH-1:1]};
            MODE_SHIFT:  res = cur >> 1;
            MODE_INVERT: res = ~cur;
            MODE_ROTATE: res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            MODE_BOUNCE: res = bounce_led(cur, dir);
            MODE_COUNT:  res = cur + {{(WIDTH-1){1'b0}}, 1'b1};
            MODE_CLEAR:  res = {WIDTH{1'b0}};
            default:     res = {WIDTH{1'b0}};
        endcase
        return res;
    endfunction

    // Next-state logic: load beats a step edge; en low freezes everything.
    always_comb begin
        cnt_d       = cnt_q;
        led_d       = led_q;
        dir_d       = dir_q;
        step_d      = 1'b0;
        step_edge_s = en && (cnt_q == CNT_MAX);
        if (load) begin
            led_d = seed;
            cnt_d = {CW{1'b0}};
            dir_d = 1'b0;
        end else if (step_edge_s) begin
            cnt_d  = {CW{1'b0}};
            led_d  = next_led(led_q, mode, dir_q);
            step_d = 1'b1;
            // Direction only moves on bounce steps so other modes keep it intact.
            if (mode == MODE_BOUNCE) begin
                dir_d = bounce_dir(led_q, dir_q);
            end else begin
                dir_d = dir_q;
            end
        end else if (en) begin
            cnt_d = cnt_q + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that also discards the prescaler phase.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= {CW{1'b0}};
            led_q  <= {WIDTH{1'b0}};
            dir_q  <= 1'b0;
            step_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            led_q  <= led_d;
            dir_q  <= dir_d;
            step_q <= step_d;
        end
    end

    assign led  = led_q;
    assign step = step_q;

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 Parameter WIDTH, default 8, number of LED outputs; SHALL be >= 2.
REQ-002 Parameter DIV, default 4, enabled clocks per pattern step; SHALL be >= 1.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 en  input  1  prescaler enable; while low, prescaler and pattern SHALL hold.
REQ-006 mode  input  3  pattern select, sampled at each step edge.
REQ-007 load  input  1  synchronous load request for seed.
REQ-008 seed  input  WIDTH  value loaded into led on load.
REQ-009 led  output  WIDTH  registered pattern output.
REQ-010 step  output  1  registered pulse, high for exactly the one cycle after each pattern step.

Function
REQ-011 Internal prescaler cnt, width ceil(log2(DIV)) (min 1 bit), SHALL count 0..DIV-1 on clocks with en=1.
REQ-012 Step edge: the edge where en=1 and cnt==DIV-1; cnt SHALL return to 0 and led SHALL take next(led, mode).
- With DIV=1, every enabled clock is a step edge.
REQ-013 step SHALL be 1 in the cycle after a step edge, else 0; no step pulse for load.
REQ-014 next() per mode:
- 0 hold: led unchanged.
- 1 fill: {1, led[WIDTH-1:1]}; if led is all ones, next is 0.
- 2 shift: led >> 1, zero fill.
- 3 invert: ~led.
- 4 rotate: rotate left by 1, MSB into bit 0.
- 5 bounce: see REQ-015.
- 6 count: led + 1 modulo 2^WIDTH; all ones wraps to 0.
- 7 clear: 0.
REQ-015 Bounce uses an internal dir register (0=left, 1=right):
- led==0: next = 1 (bit 0 set), dir<=0.
- dir=0 and led[WIDTH-1]=1: dir<=1, next = led >> 1.
- dir=1 and led[0]=1: dir<=0, next = led << 1.
- Otherwise: shift one place in the dir direction, zero fill.
- dir SHALL change only on bounce-mode step edges.
REQ-016 load=1 SHALL set led<=seed, cnt<=0, dir<=0 on that edge, regardless of en.
- load overrides any coincident step edge: no step pulse and no next() that cycle.
REQ-017 A mode change between steps SHALL take effect at the next step edge only; cnt is not disturbed.
REQ-018 Deasserting en mid-count SHALL freeze cnt; counting resumes from the frozen value.

Reset
REQ-019 On any edge with rst=1: led=0, cnt=0, dir=0, step=0.
REQ-020 rst SHALL override load, en and any step edge in the same cycle.
REQ-021 Reset mid-operation SHALL fully discard the prescaler phase; the first step after rst falls is DIV enabled clocks later.

Verification (WIDTH=8, DIV=4)
REQ-022 Reset: rst=1 for 2 clocks with load=1, seed=0xFF -> led=0x00, step=0 throughout and after release.
REQ-023 Invert: load seed 0x81, then mode=3, en=1 -> led 0x7E after 4 clocks, 0x81 after 8; step high one cycle after each step edge.
REQ-024 Fill and wrap: seed 0x00, mode=1 -> successive steps 0x80, 0xC0, ..., 0xFF, 0x00.
REQ-025 Bounce: seed 0x40, mode=5 -> 0x80, 0x40, 0x20, ..., 0x01, 0x02; seed 0x00 -> first step 0x01.
REQ-026 Count and en: seed 0xFE, mode=6 -> 0xFF, then 0x00.
- en dropped after 2 enabled clocks for 5 clocks -> led holds; next step lands 2 enabled clocks after en returns.
REQ-027 Load collision: load=1 on a step edge with seed 0x5A -> led=0x5A, step=0 next cycle, cnt restarts at 0.
